truth_table_scanner: RTL and testbench

- Sequencing controller that drives all 2^N_IN input combinations into an external combinational logic function and captures its output into a truth-table register.
- After the sweep it compares the captured table against an expected table and reports pass/fail.
- Sits beside any truth-table logic block, such as the 3-input f-function family. It serves as the on-chip self-check / characterisation engine for those blocks.

---
 rtl/tt_scan_pkg.sv | 21 ++
 rtl/truth_table_scanner_if.sv | 46 ++++
 rtl/tt_settle_timer.sv | 36 +++
 rtl/truth_table_scanner.sv | 145 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_scan_pkg.sv
// -----------------------------------------------------------------------------
// tt_scan_pkg
// Shared types and constants for the truth-table scanner slice.
//   state_t       : scanner FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   TT_F3_GOLDEN  : expected table for f = (x3 & ~x2) | (~x3 & ~x1)
//   SETTLE_W      : width of the settle counter (SETTLE is limited to 1..15)
// -----------------------------------------------------------------------------
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] TT_F3_GOLDEN = 8'h35;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/truth_table_scanner_if.sv
// -----------------------------------------------------------------------------
// truth_table_scanner_if
// Control/result bus of the truth-table scanner.
//   start     : request a scan (master -> scanner)
//   expected  : golden table, bit i = expected f for vector i (master -> scanner)
//   busy      : scan in progress (scanner -> master)
//   done      : one-cycle end-of-scan pulse (scanner -> master)
//   tt_table  : captured truth table, bit i = f observed for x=i
//   match     : tt_table equals the expected table latched at start
// Optional (macro TT_SCAN_FIRST_FAIL_EN): first_fail, fail_seen.
// -----------------------------------------------------------------------------
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    localparam int TBL_W = 1 << N_IN;

    logic             start;
    logic [TBL_W-1:0] expected;
    logic             busy;
    logic             done;
    logic [TBL_W-1:0] tt_table;
    logic             match;
`ifdef TT_SCAN_FIRST_FAIL_EN
    logic [N_IN-1:0]  first_fail;
    logic             fail_seen;

    modport master (
        output start, expected,
        input  busy, done, tt_table, match, first_fail, fail_seen
    );
    modport slave (
        input  start, expected,
        output busy, done, tt_table, match, first_fail, fail_seen
    );
`else
    modport master (
        output start, expected,
        input  busy, done, tt_table, match
    );
    modport slave (
        input  start, expected,
        output busy, done, tt_table, match
    );
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// Loadable down-counter with a zero flag; times how long an input vector is
// held before the scanner samples f.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val (has priority over dec)
//   load_val  : reload value
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
// -----------------------------------------------------------------------------
module tt_settle_timer
    import tt_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
// Drives all 2^N_IN input vectors into an external combinational function,
// captures its output into a truth table and compares it with a golden table.
//   clk, rst : clock, synchronous active-high reset
//   x        : vector driven to the function (x[N_IN-1] is the MSB)
//   f        : function output, sampled in SAMPLE
//   bus      : truth_table_scanner_if.slave (start, expected, busy, done,
//              tt_table, match [, first_fail, fail_seen])
// Parameters: N_IN (function inputs), SETTLE (1..15 cycles held before sample).
// Optional feature macro: TT_SCAN_FIRST_FAIL_EN (first failing vector report).
// -----------------------------------------------------------------------------
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    output logic [N_IN-1:0]       x,
    input  logic                  f,
    truth_table_scanner_if.slave  bus
);

    localparam int                  TBL_W       = 1 << N_IN;
    localparam logic [N_IN-1:0]     IDX_LAST    = N_IN'(TBL_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    state_t           state_reg;
    logic [N_IN-1:0]  idx_reg;
    logic [N_IN-1:0]  x_reg;
    logic [TBL_W-1:0] exp_reg;
    logic [TBL_W-1:0] tbl_reg;
    logic [TBL_W-1:0] tbl_next;
    logic             busy_reg;
    logic             done_reg;
    logic             match_reg;
`ifdef TT_SCAN_FIRST_FAIL_EN
    logic [N_IN-1:0]  first_fail_reg;
    logic             fail_seen_reg;
`endif

    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    // Table as it will be after the current SAMPLE edge; used so that match
    // is already valid in the cycle done is high.
    for (genvar gi = 0; gi < TBL_W; gi++) begin : g_tbl_next
        assign tbl_next[gi] = (idx_reg == N_IN'(gi)) ? f : tbl_reg[gi];
    end

    // Reload on scan acceptance and when moving on to the next vector.
    assign timer_load = ((state_reg == IDLE) && bus.start) ||
                        ((state_reg == SAMPLE) && (idx_reg != IDX_LAST));
    assign timer_dec  = (state_reg == DRIVE);

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            x_reg          <= '0;
            exp_reg        <= '0;
            tbl_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            match_reg      <= 1'b0;
`ifdef TT_SCAN_FIRST_FAIL_EN
            first_fail_reg <= '0;
            fail_seen_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    x_reg <= '0;
                    if (bus.start) begin
                        exp_reg        <= bus.expected;
                        tbl_reg        <= '0;
                        match_reg      <= 1'b0;
                        idx_reg        <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= DRIVE;
`ifdef TT_SCAN_FIRST_FAIL_EN
                        first_fail_reg <= '0;
                        fail_seen_reg  <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    if (timer_zero) begin
                        state_reg <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tbl_reg <= tbl_next;
`ifdef TT_SCAN_FIRST_FAIL_EN
                    if ((f != exp_reg[idx_reg]) && !fail_seen_reg) begin
                        first_fail_reg <= idx_reg;
                        fail_seen_reg  <= 1'b1;
                    end
`endif
                    if (idx_reg == IDX_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        x_reg     <= '0;
                        match_reg <= (tbl_next == exp_reg);
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        x_reg     <= idx_reg + 1'b1;
                        state_reg <= DRIVE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign x            = x_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.tt_table = tbl_reg;
    assign bus.match    = match_reg;
`ifdef TT_SCAN_FIRST_FAIL_EN
    assign bus.first_fail = first_fail_reg;
    assign bus.fail_seen  = fail_seen_reg;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
// Two scanners (SETTLE=1 and SETTLE=3) each beside the 3-input f-function.
// Table-driven scans plus hand-written sequences for start-ignore and
// mid-scan reset. Optional-feature checks follow TT_SCAN_FIRST_FAIL_EN.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fzero = 1'b0;
    logic [2:0] x_a, x_b;
    logic       f_a, f_b;
    int         sel = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(3)) ifa ();
    truth_table_scanner_if #(.N_IN(3)) ifb ();

    // f = (x3 & ~x2) | (~x3 & ~x1), or tied low when fzero is set
    assign f_a = fzero ? 1'b0 : ((x_a[2] & ~x_a[1]) | (~x_a[2] & ~x_a[0]));
    assign f_b = fzero ? 1'b0 : ((x_b[2] & ~x_b[1]) | (~x_b[2] & ~x_b[0]));

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk (clk), .rst (rst), .x (x_a), .f (f_a), .bus (ifa.slave)
    );
    truth_table_scanner #(.N_IN(3), .SETTLE(3)) dut_b (
        .clk (clk), .rst (rst), .x (x_b), .f (f_b), .bus (ifb.slave)
    );

    // Selected-DUT views
    logic [2:0] x_s;
    logic       busy_s, done_s, match_s;
    logic [7:0] tbl_s;
    assign x_s     = (sel != 0) ? x_b        : x_a;
    assign busy_s  = (sel != 0) ? ifb.busy   : ifa.busy;
    assign done_s  = (sel != 0) ? ifb.done   : ifa.done;
    assign match_s = (sel != 0) ? ifb.match  : ifa.match;
    assign tbl_s   = (sel != 0) ? ifb.tt_table : ifa.tt_table;
`ifdef TT_SCAN_FIRST_FAIL_EN
    logic [2:0] ff_s;
    logic       fs_s;
    assign ff_s = (sel != 0) ? ifb.first_fail : ifa.first_fail;
    assign fs_s = (sel != 0) ? ifb.fail_seen  : ifa.fail_seen;
`endif

    typedef struct {
        string      name;
        int         settle;
        logic       fz;
        logic [7:0] expv;
        logic [7:0] tbl;
        logic       mt;
        logic [2:0] ff;
        logic       fs;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) ifb.start = v; else ifa.start = v;
    endtask

    task automatic set_exp(input logic [7:0] v);
        if (sel != 0) ifb.expected = v; else ifa.expected = v;
    endtask

    // Pulses start, checks x/busy/done every cycle and the results at done.
    task automatic run_scan(input vec_t v);
        int lat;
        int bad_x;
        int bad_ctl;
        bad_x   = 0;
        bad_ctl = 0;
        sel   = (v.settle == 3) ? 1 : 0;
        fzero = v.fz;
        @(negedge clk);
        set_exp(v.expv);
        set_start(1'b1);
        lat = 8 * (v.settle + 1);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);  // after edge k
            if (k == 0) begin
                set_start(1'b0);
                set_exp(~v.expv);  // must not affect the latched table
            end
            if (x_s !== 3'(k / (v.settle + 1))) bad_x++;
            if (busy_s !== 1'b1 || done_s !== 1'b0) bad_ctl++;
        end
        check($sformatf("%s x sequence errors", v.name), bad_x, 0);
        check($sformatf("%s busy/done during scan errors", v.name), bad_ctl, 0);
        @(negedge clk);  // after edge lat
        check($sformatf("%s done", v.name), done_s, 1);
        check($sformatf("%s busy at done", v.name), busy_s, 1);
        check($sformatf("%s x at done", v.name), x_s, 0);
        check($sformatf("%s table", v.name), tbl_s, v.tbl);
        check($sformatf("%s match", v.name), match_s, v.mt);
`ifdef TT_SCAN_FIRST_FAIL_EN
        check($sformatf("%s first_fail", v.name), ff_s, v.ff);
        check($sformatf("%s fail_seen", v.name), fs_s, v.fs);
`endif
        @(negedge clk);
        check($sformatf("%s done after", v.name), done_s, 0);
        check($sformatf("%s busy after", v.name), busy_s, 0);
        check($sformatf("%s table held", v.name), tbl_s, v.tbl);
        check($sformatf("%s match held", v.name), match_s, v.mt);
        $display("scan %s settle=%0d exp=%02h -> table=%02h match=%0d",
                 v.name, v.settle, v.expv, tbl_s, match_s);
    endtask

    initial begin
        int n_done;
        int bad_busy;

        vecs[0] = '{"golden",      1, 1'b0, 8'h35, 8'h35, 1'b1, 3'd0, 1'b0};
        vecs[1] = '{"mismatch",    1, 1'b0, 8'h34, 8'h35, 1'b0, 3'd0, 1'b1};
        vecs[2] = '{"settle3",     3, 1'b0, 8'h35, 8'h35, 1'b1, 3'd0, 1'b0};
        vecs[3] = '{"const0",      1, 1'b1, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0};
        vecs[4] = '{"const0_s3",   3, 1'b1, 8'h20, 8'h00, 1'b0, 3'd5, 1'b1};
        vecs[5] = '{"msb_differ",  1, 1'b0, 8'hB5, 8'h35, 1'b0, 3'd7, 1'b1};

        ifa.start = 1'b0; ifa.expected = 8'h00;
        ifb.start = 1'b0; ifb.expected = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check($sformatf("reset x[%0d]", s), x_s, 0);
            check($sformatf("reset busy[%0d]", s), busy_s, 0);
            check($sformatf("reset done[%0d]", s), done_s, 0);
            check($sformatf("reset table[%0d]", s), tbl_s, 0);
            check($sformatf("reset match[%0d]", s), match_s, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // Start re-pulsed while busy (edges 5, 16, and 17 = done cycle),
        // expected changed at edge 3: exactly one scan, match from latched value.
        sel = 0; fzero = 1'b0;
        @(negedge clk);
        ifa.expected = 8'h35;
        ifa.start    = 1'b1;
        n_done   = 0;
        bad_busy = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);  // after edge k
            ifa.start = (k == 4 || k == 15 || k == 16) ? 1'b1 : 1'b0;
            if (k == 2) ifa.expected = 8'h00;
            if (done_s === 1'b1) begin
                n_done++;
                check("ignore done edge", k, 16);
                check("ignore match", match_s, 1);
            end
            if (k >= 17 && busy_s !== 1'b0) bad_busy++;
        end
        check("ignore done count", n_done, 1);
        check("ignore busy after scan errors", bad_busy, 0);
        check("ignore table", tbl_s, 8'h35);
        $display("start-ignore sequence: dones=%0d table=%02h match=%0d", n_done, tbl_s, match_s);

        // Reset at edge 7 of a scan (previous results are table=35, match=1)
        @(negedge clk);
        ifa.expected = 8'h35;
        ifa.start    = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);  // after edge k
            ifa.start = 1'b0;
            if (k == 6) rst = 1'b1;
        end
        @(negedge clk);  // after edge 7
        rst = 1'b0;
        check("midrst x", x_s, 0);
        check("midrst busy", busy_s, 0);
        check("midrst table", tbl_s, 0);
        check("midrst match", match_s, 0);
        check("midrst done", done_s, 0);
        n_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done_s !== 1'b0 || busy_s !== 1'b0) n_done++;
        end
        check("midrst no done/busy afterwards", n_done, 0);
        $display("mid-scan reset: table=%02h match=%0d", tbl_s, match_s);
        run_scan(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
